// File: rtl/dma_xmit_scheduler.sv
// Descriptor FIFO and single-job issue sequencer in front of the xmit DMA data mover.
// Descriptors are screened, started one at a time, and retired with an in-order completion record.
module dma_xmit_scheduler #(
  parameter int TW            = 8,
  parameter int DEPTH_LOG2    = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [63:0]           desc_src_addr,
  input  logic [63:0]           desc_dst_addr,
  input  logic [63:0]           desc_byte_count,
  input  logic [TW-1:0]         desc_tag,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  output logic [63:0]           dm_src_address,
  output logic [63:0]           dm_dst_address,
  output logic [63:0]           dm_byte_count,
  output logic                  dm_start,
  input  logic                  dm_idle,
  output logic [TW-1:0]         cmp_tag,
  output logic [1:0]            cmp_status,
  output logic                  cmp_valid,
  input  logic                  cmp_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [31:0]           jobs_completed,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TOW   = $clog2(START_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TOW-1:0]      TIMEOUT_LAST = TOW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  logic [63:0]   src_mem [DEPTH];
  logic [63:0]   dst_mem [DEPTH];
  logic [63:0]   cnt_mem [DEPTH];
  logic [TW-1:0] tag_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TOW-1:0]        to_cnt;

  logic       push, pop;
  logic       set_status, clr_to, inc_to, cmp_fire;
  logic [1:0] status_d;

  assign desc_ready = (fifo_count != FULL_COUNT);
  assign push       = desc_valid && desc_ready;
  assign cmp_valid  = (state_q == S_REPORT);
  assign busy       = (fifo_count != '0) || (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr] <= desc_src_addr;
      dst_mem[wr_ptr] <= desc_dst_addr;
      cnt_mem[wr_ptr] <= desc_byte_count;
      tag_mem[wr_ptr] <= desc_tag;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // dm_start is decoded from registered state only, so it is a clean single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    dm_start   = 1'b0;
    set_status = 1'b0;
    status_d   = 2'd0;
    clr_to     = 1'b0;
    inc_to     = 1'b0;
    cmp_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dm_src_address == '0) begin
          set_status = 1'b1;
          status_d   = 2'd1;
          state_d    = S_REPORT;
        end else if (dm_byte_count == '0) begin
          set_status = 1'b1;
          status_d   = 2'd2;
          state_d    = S_REPORT;
        end else begin
          dm_start = 1'b1;
          clr_to   = 1'b1;
          state_d  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!dm_idle) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt == TIMEOUT_LAST) begin
          set_status = 1'b1;
          status_d   = 2'd3;
          state_d    = S_REPORT;
        end else begin
          inc_to = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (dm_idle) begin
          set_status = 1'b1;
          status_d   = 2'd0;
          state_d    = S_REPORT;
        end
      end
      S_REPORT: begin
        if (cmp_ready) begin
          cmp_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mover-facing registers only load on a pop, which keeps them steady for the whole job.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dm_src_address <= '0;
      dm_dst_address <= '0;
      dm_byte_count  <= '0;
      cmp_tag        <= '0;
      cmp_status     <= '0;
      to_cnt         <= '0;
      jobs_completed <= '0;
    end else begin
      if (pop) begin
        dm_src_address <= src_mem[rd_ptr];
        dm_dst_address <= dst_mem[rd_ptr];
        dm_byte_count  <= cnt_mem[rd_ptr];
        cmp_tag        <= tag_mem[rd_ptr];
      end
      if (set_status) cmp_status <= status_d;
      if (clr_to)      to_cnt <= '0;
      else if (inc_to) to_cnt <= to_cnt + 1'b1;
      if (cmp_fire) jobs_completed <= jobs_completed + 32'd1;
    end
  end

endmodule

// File: tb/tb_dma_xmit_scheduler.sv
// Directed bench for dma_xmit_scheduler: a descriptor vector table plus hand-built
// sequences for latency, FIFO full, start timeout, completion back-pressure and mid-job reset.
module tb_dma_xmit_scheduler;

  logic         clk;
  logic         resetn;
  logic [63:0]  desc_src_addr, desc_dst_addr, desc_byte_count;
  logic [7:0]   desc_tag;
  logic         desc_valid, desc_ready;
  logic [63:0]  dm_src_address, dm_dst_address, dm_byte_count;
  logic         dm_start, dm_idle;
  logic [7:0]   cmp_tag;
  logic [1:0]   cmp_status;
  logic         cmp_valid, cmp_ready;
  logic [4:0]   fifo_count;
  logic [31:0]  jobs_completed;
  logic         busy;

  dma_xmit_scheduler #(.TW(8), .DEPTH_LOG2(4), .START_TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .desc_src_addr(desc_src_addr), .desc_dst_addr(desc_dst_addr),
    .desc_byte_count(desc_byte_count), .desc_tag(desc_tag),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .dm_src_address(dm_src_address), .dm_dst_address(dm_dst_address),
    .dm_byte_count(dm_byte_count), .dm_start(dm_start), .dm_idle(dm_idle),
    .cmp_tag(cmp_tag), .cmp_status(cmp_status), .cmp_valid(cmp_valid),
    .cmp_ready(cmp_ready), .fifo_count(fifo_count),
    .jobs_completed(jobs_completed), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Edge counter: after a posedge, cyc holds that edge's number.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers: dm_start pulses (edge at which the mover samples it) and completion handshakes.
  int          start_cnt  = 0;
  int          start_edge = 0;
  int          rise_edge  = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] snap_src, snap_dst, snap_cnt;
  logic [9:0]  cq[$];

  always @(negedge clk) begin
    if (dm_start) begin
      start_cnt  <= start_cnt + 1;
      start_edge <= cyc + 1;
      snap_src   <= dm_src_address;
      snap_dst   <= dm_dst_address;
      snap_cnt   <= dm_byte_count;
    end
    if (cmp_valid && cmp_ready) cq.push_back({cmp_tag, cmp_status});
    if (cmp_valid && !prev_valid) rise_edge <= cyc;
    prev_valid <= cmp_valid;
  end

  // Data mover model: goes busy the cycle after a start for mover_busy cycles, or never when stuck.
  int mover_busy  = 3;
  bit mover_stuck = 1'b0;
  initial begin
    dm_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (dm_start && !mover_stuck) begin
        @(posedge clk);
        #1 dm_idle = 1'b0;
        repeat (mover_busy) @(posedge clk);
        #1 dm_idle = 1'b1;
      end
    end
  end

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] cnt;
    logic [7:0]  tag;
    logic [1:0]  exp_status;
    bit          exp_start;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int last_push_edge = 0;

  task automatic applyStimulus(input logic [63:0] src, input logic [63:0] dst,
                               input logic [63:0] cnt, input logic [7:0] tag);
    int w;
    desc_src_addr   = src;
    desc_dst_addr   = dst;
    desc_byte_count = cnt;
    desc_tag        = tag;
    desc_valid      = 1'b1;
    w = 0;
    while (!desc_ready && w < 500) begin
      tick();
      w++;
    end
    if (!desc_ready) checkOutput("desc_ready_wait", 64'(desc_ready), 64'd1);
    tick();
    last_push_edge = cyc;
    desc_valid = 1'b0;
  endtask

  task automatic waitCompletions(input int base, input int n, input int budget, input string name);
    int i;
    i = 0;
    while ((cq.size() - base) < n && i < budget) begin
      tick();
      i++;
    end
    checkOutput(name, 64'(cq.size() - base), 64'(n));
  endtask

  int base, s0, w, exp_jobs;

  initial begin
    resetn = 1'b0;
    desc_valid = 1'b0;
    desc_src_addr = '0;
    desc_dst_addr = '0;
    desc_byte_count = '0;
    desc_tag = '0;
    cmp_ready = 1'b0;
    exp_jobs = 0;

    vecs[0] = '{64'hDEAD_BEEF_0000_1000, 64'h1, 64'd64, 8'h11, 2'd0, 1'b1};
    vecs[1] = '{64'h0, 64'h3000, 64'd16, 8'h03, 2'd1, 1'b0};
    vecs[2] = '{64'h4000, 64'h5000, 64'd0, 8'h04, 2'd2, 1'b0};
    vecs[3] = '{64'h0, 64'h0, 64'd0, 8'h22, 2'd1, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'hFF, 2'd0, 1'b1};
    vecs[5] = '{64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 2'd0, 1'b1};

    // Reset values.
    repeat (3) tick();
    checkOutput("rst_desc_ready", 64'(desc_ready), 64'd1);
    checkOutput("rst_fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("rst_dm_start", 64'(dm_start), 64'd0);
    checkOutput("rst_dm_src", dm_src_address, 64'd0);
    checkOutput("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    checkOutput("rst_cmp_tag", 64'(cmp_tag), 64'd0);
    checkOutput("rst_jobs", 64'(jobs_completed), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    tick();

    // Nominal job: start two edges after the push, dm_* match, status OK.
    cmp_ready = 1'b1;
    mover_busy = 20;
    base = cq.size();
    s0 = start_cnt;
    applyStimulus(64'h1000, 64'h2000, 64'd8192, 8'd5);
    waitCompletions(base, 1, 200, "nom_cmp_arrived");
    exp_jobs++;
    checkOutput("nom_starts", 64'(start_cnt - s0), 64'd1);
    checkOutput("nom_latency", 64'(start_edge - last_push_edge), 64'd2);
    checkOutput("nom_dm_src", snap_src, 64'h1000);
    checkOutput("nom_dm_dst", snap_dst, 64'h2000);
    checkOutput("nom_dm_cnt", snap_cnt, 64'd8192);
    if (cq.size() > base) begin
      checkOutput("nom_cmp_tag", 64'(cq[base][9:2]), 64'd5);
      checkOutput("nom_cmp_status", 64'(cq[base][1:0]), 64'd0);
    end
    checkOutput("nom_jobs", 64'(jobs_completed), 64'(exp_jobs));

    // Vector table, one descriptor at a time.
    mover_busy = 3;
    for (int i = 0; i < 6; i++) begin
      base = cq.size();
      s0 = start_cnt;
      applyStimulus(vecs[i].src, vecs[i].dst, vecs[i].cnt, vecs[i].tag);
      waitCompletions(base, 1, 300, $sformatf("vec%0d_cmp_arrived", i));
      exp_jobs++;
      if (cq.size() > base) begin
        checkOutput($sformatf("vec%0d_tag", i), 64'(cq[base][9:2]), 64'(vecs[i].tag));
        checkOutput($sformatf("vec%0d_status", i), 64'(cq[base][1:0]), 64'(vecs[i].exp_status));
      end
      checkOutput($sformatf("vec%0d_starts", i), 64'(start_cnt - s0), 64'(vecs[i].exp_start));
      if (vecs[i].exp_start) begin
        checkOutput($sformatf("vec%0d_dm_src", i), snap_src, vecs[i].src);
        checkOutput($sformatf("vec%0d_dm_dst", i), snap_dst, vecs[i].dst);
        checkOutput($sformatf("vec%0d_dm_cnt", i), snap_cnt, vecs[i].cnt);
      end
      checkOutput($sformatf("vec%0d_jobs", i), 64'(jobs_completed), 64'(exp_jobs));
      checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
    end

    // Two screened descriptors queued together retire in order without any start.
    base = cq.size();
    s0 = start_cnt;
    applyStimulus(64'h0, 64'h7000, 64'd32, 8'd3);
    applyStimulus(64'h7000, 64'h8000, 64'd0, 8'd4);
    waitCompletions(base, 2, 100, "scr_cmp_arrived");
    exp_jobs += 2;
    if (cq.size() > base + 1) begin
      checkOutput("scr_first", 64'(cq[base]), 64'({8'd3, 2'd1}));
      checkOutput("scr_second", 64'(cq[base+1]), 64'({8'd4, 2'd2}));
    end
    checkOutput("scr_starts", 64'(start_cnt - s0), 64'd0);

    // FIFO full: park a screened job in report, then fill all 16 slots and offer a 17th.
    cmp_ready = 1'b0;
    mover_busy = 5;
    base = cq.size();
    applyStimulus(64'h0, 64'h0, 64'd8, 8'h40);
    w = 0;
    while (!cmp_valid && w < 50) begin
      tick();
      w++;
    end
    checkOutput("full_blocker_valid", 64'(cmp_valid), 64'd1);
    for (int i = 0; i < 16; i++)
      applyStimulus(64'h1000 + 64'(i) * 64'h100, 64'h8000, 64'd32, 8'(i));
    checkOutput("full_count", 64'(fifo_count), 64'd16);
    checkOutput("full_ready", 64'(desc_ready), 64'd0);
    desc_tag = 8'h99;
    desc_src_addr = 64'h9900;
    desc_byte_count = 64'd4;
    desc_valid = 1'b1;
    repeat (5) tick();
    checkOutput("full_hold_count", 64'(fifo_count), 64'd16);
    desc_valid = 1'b0;
    cmp_ready = 1'b1;
    waitCompletions(base, 17, 3000, "full_cmp_arrived");
    exp_jobs += 17;
    if (cq.size() >= base + 17) begin
      checkOutput("full_blocker", 64'(cq[base]), 64'({8'h40, 2'd1}));
      for (int i = 0; i < 16; i++)
        checkOutput($sformatf("full_order%0d", i), 64'(cq[base+1+i]), 64'({8'(i), 2'd0}));
    end
    repeat (20) tick();
    checkOutput("full_no_extra", 64'(cq.size() - base), 64'd17);
    checkOutput("full_jobs", 64'(jobs_completed), 64'(exp_jobs));

    // Start timeout: mover never leaves idle, report lands 16 edges after the start edge.
    mover_stuck = 1'b1;
    base = cq.size();
    s0 = start_cnt;
    applyStimulus(64'h10, 64'h20, 64'd4, 8'h70);
    waitCompletions(base, 1, 200, "to_cmp_arrived");
    if (cq.size() > base) checkOutput("to_cmp", 64'(cq[base]), 64'({8'h70, 2'd3}));
    checkOutput("to_starts", 64'(start_cnt - s0), 64'd1);
    checkOutput("to_delay", 64'(rise_edge - start_edge), 64'd16);
    mover_stuck = 1'b0;
    base = cq.size();
    applyStimulus(64'h30, 64'h40, 64'd12, 8'h71);
    waitCompletions(base, 1, 200, "to_next_arrived");
    if (cq.size() > base) checkOutput("to_next_cmp", 64'(cq[base]), 64'({8'h71, 2'd0}));
    exp_jobs += 2;

    // Completion back-pressure: record held steady, no new start until accepted.
    cmp_ready = 1'b0;
    mover_busy = 3;
    base = cq.size();
    applyStimulus(64'h500, 64'h600, 64'd16, 8'h50);
    applyStimulus(64'h700, 64'h800, 64'd16, 8'h51);
    w = 0;
    while (!cmp_valid && w < 100) begin
      tick();
      w++;
    end
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("hold%0d_valid", i), 64'(cmp_valid), 64'd1);
      checkOutput($sformatf("hold%0d_tag", i), 64'(cmp_tag), 64'h50);
      checkOutput($sformatf("hold%0d_status", i), 64'(cmp_status), 64'd0);
    end
    checkOutput("hold_no_start", 64'(start_cnt - s0), 64'd0);
    cmp_ready = 1'b1;
    waitCompletions(base, 2, 200, "hold_cmp_arrived");
    exp_jobs += 2;
    if (cq.size() > base + 1) checkOutput("hold_second", 64'(cq[base+1]), 64'({8'h51, 2'd0}));
    checkOutput("hold_starts", 64'(start_cnt - s0), 64'd1);
    checkOutput("hold_jobs", 64'(jobs_completed), 64'(exp_jobs));

    // Reset while the mover is busy with three descriptors still queued.
    mover_busy = 30;
    for (int i = 0; i < 4; i++)
      applyStimulus(64'h2000 + 64'(i), 64'h3000, 64'd64, 8'(8'h60 + i));
    repeat (5) tick();
    checkOutput("mid_count", 64'(fifo_count), 64'd3);
    checkOutput("mid_busy", 64'(busy), 64'd1);
    base = cq.size();
    #2 resetn = 1'b0;
    #1;
    checkOutput("mid_rst_count", 64'(fifo_count), 64'd0);
    checkOutput("mid_rst_ready", 64'(desc_ready), 64'd1);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_dm_src", dm_src_address, 64'd0);
    checkOutput("mid_rst_jobs", 64'(jobs_completed), 64'd0);
    checkOutput("mid_rst_valid", 64'(cmp_valid), 64'd0);
    repeat (3) tick();
    resetn = 1'b1;
    s0 = start_cnt;
    repeat (60) tick();
    checkOutput("post_rst_no_cmp", 64'(cq.size() - base), 64'd0);
    checkOutput("post_rst_no_start", 64'(start_cnt - s0), 64'd0);
    checkOutput("post_rst_jobs", 64'(jobs_completed), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
